instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit.sv | 82 ++++++++
 tb/tb_instruction_fetch_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS front end, fetches words and hands Instruction/Pc to decode with valid/accept
// Ports: clk/reset (sync, active-high); imem_req/imem_addr/imem_ready/imem_rdata memory side;
// Instruction/Pc/instr_valid/instr_accept decode side; jump/jumpLink/jumpReg/branchatall/bne/zero/imm/addr/reg_target
// redirect inputs; link_addr = Pc+4; instr_count retire counter, built only with FETCH_RETIRE_COUNT_EN (else tied to 0).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] Pc,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        jump,
  input  logic        jumpLink,
  input  logic        jumpReg,
  input  logic        branchatall,
  input  logic        bne,
  input  logic        zero,
  input  logic [15:0] imm,
  input  logic [31:0] addr,
  input  logic [31:0] reg_target,
  output logic [31:0] link_addr,
  output logic [31:0] instr_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, seq_pc, next_pc;
  logic taken, retire;
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? FETCH :
              state_q == FETCH ? (imem_ready ? HOLD : FETCH) :
              state_q == HOLD  ? (instr_accept ? FETCH : HOLD) : IDLE;
  end
  always_comb begin
    imem_req    = state_q == FETCH;
    instr_valid = state_q == HOLD;
  end
  // Redirect inputs only matter on the accept cycle; priority jr > j/jal > branch > sequential.
  always_comb begin
    seq_pc  = pc_q + 32'd4;
    taken   = branchatall & (bne ? ~zero : zero);
    next_pc = jumpReg ? (reg_target & ~32'd3) :
              (jump | jumpLink) ? addr :
              taken ? seq_pc + {{14{imm[15]}}, imm, 2'b00} : seq_pc;
    retire  = instr_valid & instr_accept;
    pc_d    = retire ? next_pc : pc_q;
    instr_d = (imem_req & imem_ready) ? imem_rdata : instr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end
  assign Pc          = pc_q;
  assign imem_addr   = pc_q;
  assign Instruction = instr_q;
  assign link_addr   = seq_pc;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + {31'd0, retire};
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign instr_count = cnt_q;
`else
  assign instr_count = 32'h0;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized and directed checks of the fetch unit against a PC reference model
module tb_instruction_fetch_unit;
  localparam logic [31:0] RPC = 32'h00400000;
  logic clk = 0, reset = 1;
  logic imem_req, imem_ready = 0, instr_valid, instr_accept = 0;
  logic jump = 0, jumpLink = 0, jumpReg = 0, branchatall = 0, bne = 0, zero = 0;
  logic [15:0] imm = 0;
  logic [31:0] imem_addr, imem_rdata = 0, Instruction, Pc, addr = 0, reg_target = 0, link_addr, instr_count;
  logic [31:0] exp_pc, exp_instr, exp_cnt;
  int errs = 0, checks = 0;
  instruction_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .Instruction(Instruction), .Pc(Pc), .instr_valid(instr_valid),
    .instr_accept(instr_accept), .jump(jump), .jumpLink(jumpLink), .jumpReg(jumpReg),
    .branchatall(branchatall), .bne(bne), .zero(zero), .imm(imm), .addr(addr),
    .reg_target(reg_target), .link_addr(link_addr), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input bit jr, input bit j, input bit jl,
                                           input bit br, input bit bn, input bit z, input logic [15:0] im,
                                           input logic [31:0] a, input logic [31:0] rt);
    if (jr) return {rt[31:2], 2'b00};
    if (j || jl) return a;
    if (br && (bn ? !z : z)) return pc + 32'd4 + 32'($signed(im)) * 32'd4;
    return pc + 32'd4;
  endfunction
  function automatic logic [31:0] cnt_exp();
`ifdef FETCH_RETIRE_COUNT_EN
    return exp_cnt;
`else
    return 32'h0;
`endif
  endfunction
  task automatic do_reset();
    reset = 1; imem_ready = 0; instr_accept = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc", Pc, RPC); chk("rst_instr", Instruction, 0); chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0); chk("rst_cnt", instr_count, 0);
    reset = 0; exp_pc = RPC; exp_cnt = 0;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    chk("req_timeout", imem_req, 1);
  endtask
  task automatic fetch(input logic [31:0] d, input int lat);
    wait_req();
    chk("imem_addr", imem_addr, exp_pc);
    chk("valid_in_fetch", instr_valid, 0);
    repeat (lat) begin
      @(negedge clk);
      chk("req_held", imem_req, 1); chk("addr_held", imem_addr, exp_pc);
    end
    imem_ready = 1; imem_rdata = d;
    @(negedge clk);
    imem_ready = 0; imem_rdata = $urandom;
    exp_instr = d;
    chk("valid", instr_valid, 1); chk("instr", Instruction, d); chk("pc", Pc, exp_pc); chk("req_off", imem_req, 0);
  endtask
  task automatic retire(input int hold, input bit jr, input bit j, input bit jl, input bit br, input bit bn,
                        input bit z, input logic [15:0] im, input logic [31:0] a, input logic [31:0] rt);
    repeat (hold) begin
      // junk on redirect lines and stray imem_ready must not disturb HOLD
      {jumpReg, jump, jumpLink, branchatall, bne, zero} = 6'($urandom);
      addr = $urandom; reg_target = $urandom; imm = 16'($urandom);
      imem_ready = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
      imem_ready = 0;
      chk("hold_instr", Instruction, exp_instr); chk("hold_pc", Pc, exp_pc);
      chk("hold_valid", instr_valid, 1); chk("hold_req", imem_req, 0);
    end
    jumpReg = jr; jump = j; jumpLink = jl; branchatall = br; bne = bn; zero = z;
    imm = im; addr = a; reg_target = rt; instr_accept = 1;
    chk("link_addr", link_addr, exp_pc + 32'd4);
    chk("count", instr_count, cnt_exp());
    @(negedge clk);
    instr_accept = 0; {jumpReg, jump, jumpLink, branchatall, bne, zero} = '0;
    exp_pc = ref_next(exp_pc, jr, j, jl, br, bn, z, im, a, rt);
    exp_cnt++;
    chk("valid_drop", instr_valid, 0);
    chk("next_pc", Pc, exp_pc);
  endtask
  initial begin
    do_reset();
    fetch(32'h20080005, 0);
    retire(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch(32'h1, 1); retire(0, 0, 1, 0, 0, 0, 0, 0, 32'h00400010, 0);
    fetch(32'h1000FFFC, 0); retire(0, 0, 0, 0, 1, 0, 1, 16'hFFFC, 0, 0);
    chk("beq_taken", Pc, 32'h00400004);
    fetch(32'h2, 2); retire(1, 0, 1, 0, 0, 0, 0, 0, 32'h00400010, 0);
    fetch(32'h1400FFFC, 0); retire(0, 0, 0, 0, 1, 1, 1, 16'hFFFC, 0, 0);
    chk("bne_not_taken", Pc, 32'h00400014);
    fetch(32'h3, 0); retire(0, 1, 1, 0, 0, 0, 0, 0, 32'h00400100, 32'h0040002B);
    chk("jr_priority", Pc, 32'h00400028);
    fetch(32'h4, 0); retire(0, 0, 1, 0, 0, 0, 0, 0, 32'h00400020, 0);
    fetch(32'h0C100000, 0);
    chk("jal_link", link_addr, 32'h00400024);
    retire(0, 0, 0, 1, 1, 0, 1, 16'h0005, 32'h00400300, 0);
    fetch(32'h5, 0); retire(0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 0);
    fetch(32'h6, 0); retire(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_req();
    chk("wrap_addr", imem_addr, 32'h00000000);
    for (int i = 0; i < 60; i++) begin
      fetch($urandom, $urandom_range(0, 3));
      retire($urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
             16'($urandom), $urandom, $urandom);
    end
    do_reset();
    repeat (3) begin fetch($urandom, 0); retire(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); end
    wait_req();
    chk("count_three", instr_count, cnt_exp());
    reset = 1;
    @(negedge clk);
    chk("midrst_pc", Pc, RPC); chk("midrst_valid", instr_valid, 0);
    chk("midrst_req", imem_req, 0); chk("midrst_cnt", instr_count, 0);
    reset = 0; imem_ready = 1; imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_ready = 0;
    chk("late_valid", instr_valid, 0); chk("late_instr", Instruction, 0); chk("late_req", imem_req, 1);
    exp_pc = RPC; exp_cnt = 0;
    fetch(32'h7, 0); retire(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
